// File: rtl/ctrl_decode_stage.sv
// Pipelined opcode decoder: registers the control bundle into the ID/EX boundary with
// valid/ready handshake, flush, load-use stall and saturating statistics. Optional: CTRL_ILLEGAL_TRAP_EN.
module ctrl_decode_stage #(
    parameter int unsigned OPCODE_W   = 6,
    parameter int unsigned ALU_CMD_W  = 4,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned STAT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic [REG_ADDR_W-1:0] src1,
    input  logic [REG_ADDR_W-1:0] src2,
    input  logic [REG_ADDR_W-1:0] dest,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ALU_CMD_W-1:0]  alu_command,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  wb_enable,
    output logic                  is_immediate,
    output logic                  is_single_source,
    output logic [1:0]            branch,
    output logic [REG_ADDR_W-1:0] out_src1,
    output logic [REG_ADDR_W-1:0] out_src2,
    output logic [REG_ADDR_W-1:0] out_dest,
    output logic [STAT_W-1:0]     stall_count,
    output logic [STAT_W-1:0]     flush_count
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic                  illegal_op
`endif
);

    typedef struct packed {
        logic [ALU_CMD_W-1:0] alu;
        logic                 wb;
        logic                 imm;
        logic                 mem_r;
        logic                 mem_w;
        logic [1:0]           branch;
        logic                 single;
    } ctrl_t;

    // Widen to at least 6 bits so every opcode constant is representable; upper bits must be zero.
    localparam int unsigned OW = (OPCODE_W > 6) ? OPCODE_W : 6;

    logic [OW-1:0]         op_w;
    ctrl_t                 dec;
    logic                  dec_legal;
    logic                  uses_src1;
    logic                  uses_src2;
    logic                  hazard;
    logic                  accept;
    ctrl_t                 ctrl_q;
    logic [REG_ADDR_W-1:0] src1_q;
    logic [REG_ADDR_W-1:0] src2_q;
    logic [REG_ADDR_W-1:0] dest_q;

    assign op_w = OW'(opcode);

    always_comb begin
        dec       = '0;
        dec_legal = 1'b1;
        case (op_w)
            OW'(0):  begin end
            OW'(1):  begin dec.alu = ALU_CMD_W'(0);  dec.wb = 1'b1; end
            OW'(3):  begin dec.alu = ALU_CMD_W'(2);  dec.wb = 1'b1; end
            OW'(5):  begin dec.alu = ALU_CMD_W'(4);  dec.wb = 1'b1; end
            OW'(6):  begin dec.alu = ALU_CMD_W'(5);  dec.wb = 1'b1; end
            OW'(7):  begin dec.alu = ALU_CMD_W'(6);  dec.wb = 1'b1; end
            OW'(8):  begin dec.alu = ALU_CMD_W'(7);  dec.wb = 1'b1; end
            OW'(9):  begin dec.alu = ALU_CMD_W'(8);  dec.wb = 1'b1; end
            OW'(10): begin dec.alu = ALU_CMD_W'(8);  dec.wb = 1'b1; end
            OW'(11): begin dec.alu = ALU_CMD_W'(9);  dec.wb = 1'b1; end
            OW'(12): begin dec.alu = ALU_CMD_W'(10); dec.wb = 1'b1; end
            OW'(32): begin dec.alu = ALU_CMD_W'(0); dec.wb = 1'b1; dec.imm = 1'b1; dec.single = 1'b1; end
            OW'(33): begin dec.alu = ALU_CMD_W'(2); dec.wb = 1'b1; dec.imm = 1'b1; dec.single = 1'b1; end
            OW'(36): begin
                dec.alu    = ALU_CMD_W'(0);
                dec.mem_r  = 1'b1;
                dec.wb     = 1'b1;
                dec.imm    = 1'b1;
                dec.single = 1'b1;
            end
            OW'(37): begin dec.alu = ALU_CMD_W'(0); dec.mem_w = 1'b1; dec.imm = 1'b1; end
            OW'(40): begin dec.imm = 1'b1; dec.branch = 2'b01; dec.single = 1'b1; end
            OW'(41): begin dec.imm = 1'b1; dec.branch = 2'b10; end
            OW'(42): begin dec.imm = 1'b1; dec.branch = 2'b11; dec.single = 1'b1; end
            default: dec_legal = 1'b0;
        endcase
    end

    // Undefined opcodes behave as NOP, so they use no source registers.
    assign uses_src1 = dec_legal && (op_w != '0) && (op_w != OW'(42));
    assign uses_src2 = dec_legal && (op_w != '0) && !dec.single;

    assign hazard = out_valid && ctrl_q.mem_r && (dest_q != '0) &&
                    ((uses_src1 && (src1 == dest_q)) || (uses_src2 && (src2 == dest_q)));

    assign in_ready = !rst && !flush && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            ctrl_q      <= '0;
            src1_q      <= '0;
            src2_q      <= '0;
            dest_q      <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else if (flush) begin
            out_valid   <= 1'b0;
            ctrl_q      <= '0;
            src1_q      <= '0;
            src2_q      <= '0;
            dest_q      <= '0;
            flush_count <= sat_inc(flush_count);
        end else if (accept) begin
            out_valid <= 1'b1;
            ctrl_q    <= dec;
            src1_q    <= src1;
            src2_q    <= src2;
            dest_q    <= dest;
        end else if (out_valid && out_ready) begin
            // Bubble: only counted as a stall when a real instruction was held back by the load.
            out_valid <= 1'b0;
            ctrl_q    <= '0;
            src1_q    <= '0;
            src2_q    <= '0;
            dest_q    <= '0;
            if (hazard && in_valid) begin
                stall_count <= sat_inc(stall_count);
            end
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_op <= 1'b0;
        end else if (accept && !dec_legal) begin
            illegal_op <= 1'b1;
        end
    end
`endif

    assign alu_command      = ctrl_q.alu;
    assign mem_read         = ctrl_q.mem_r;
    assign mem_write        = ctrl_q.mem_w;
    assign wb_enable        = ctrl_q.wb;
    assign is_immediate     = ctrl_q.imm;
    assign is_single_source = ctrl_q.single;
    assign branch           = ctrl_q.branch;
    assign out_src1         = src1_q;
    assign out_src2         = src2_q;
    assign out_dest         = dest_q;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Scoreboard bench for ctrl_decode_stage: directed test-plan sequences plus randomized traffic
// against a transaction-level reference model; illegal_op checked when CTRL_ILLEGAL_TRAP_EN is set.
module tb_ctrl_decode_stage;

    localparam int STAT_W = 2;
    localparam int SMAX   = (1 << STAT_W) - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [5:0] opcode = '0;
    logic [4:0] src1 = '0;
    logic [4:0] src2 = '0;
    logic [4:0] dest = '0;
    logic       flush = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] alu_command;
    logic       mem_read;
    logic       mem_write;
    logic       wb_enable;
    logic       is_immediate;
    logic       is_single_source;
    logic [1:0] branch;
    logic [4:0] out_src1;
    logic [4:0] out_src2;
    logic [4:0] out_dest;
    logic [STAT_W-1:0] stall_count;
    logic [STAT_W-1:0] flush_count;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic       illegal_op;
`endif

    ctrl_decode_stage #(
        .OPCODE_W  (6),
        .ALU_CMD_W (4),
        .REG_ADDR_W(5),
        .STAT_W    (STAT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .opcode          (opcode),
        .src1            (src1),
        .src2            (src2),
        .dest            (dest),
        .flush           (flush),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .alu_command     (alu_command),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .wb_enable       (wb_enable),
        .is_immediate    (is_immediate),
        .is_single_source(is_single_source),
        .branch          (branch),
        .out_src1        (out_src1),
        .out_src2        (out_src2),
        .out_dest        (out_dest),
        .stall_count     (stall_count),
        .flush_count     (flush_count)
`ifdef CTRL_ILLEGAL_TRAP_EN
        ,
        .illegal_op      (illegal_op)
`endif
    );

    always #5 clk = ~clk;

    // {alu[3:0], mem_r, mem_w, wb, imm, single, branch[1:0]} followed by the three register fields
    typedef struct packed {
        logic [10:0] ctl;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [4:0]  d;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model state: the instruction sitting in the ID/EX register, and the statistics.
    bit  m_valid;
    int  m_op, m_d;
    int  m_stall, m_flush;
    bit  m_illegal;

    int  legal_ops[18] = '{0, 1, 3, 5, 6, 7, 8, 9, 10, 11, 12, 32, 33, 36, 37, 40, 41, 42};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [10:0] ref_ctl(input int op, output bit legal);
        legal = 1'b1;
        case (op)
            0:  return 11'd0;
            1:  return {4'd0,  5'b00100, 2'b00};
            3:  return {4'd2,  5'b00100, 2'b00};
            5:  return {4'd4,  5'b00100, 2'b00};
            6:  return {4'd5,  5'b00100, 2'b00};
            7:  return {4'd6,  5'b00100, 2'b00};
            8:  return {4'd7,  5'b00100, 2'b00};
            9:  return {4'd8,  5'b00100, 2'b00};
            10: return {4'd8,  5'b00100, 2'b00};
            11: return {4'd9,  5'b00100, 2'b00};
            12: return {4'd10, 5'b00100, 2'b00};
            32: return {4'd0,  5'b00111, 2'b00};
            33: return {4'd2,  5'b00111, 2'b00};
            36: return {4'd0,  5'b10111, 2'b00};
            37: return {4'd0,  5'b01010, 2'b00};
            40: return {4'd0,  5'b00011, 2'b01};
            41: return {4'd0,  5'b00010, 2'b10};
            42: return {4'd0,  5'b00011, 2'b11};
            default: begin
                legal = 1'b0;
                return 11'd0;
            end
        endcase
    endfunction

    function automatic logic [10:0] dut_ctl();
        return {alu_command, mem_read, mem_write, wb_enable, is_immediate, is_single_source, branch};
    endfunction

    exp_t mon_act;
    exp_t mon_exp;
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready && !flush) begin
            mon_act = {dut_ctl(), out_src1, out_src2, out_dest};
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_bundle at %0t: got 0x%0h expected none", $time, mon_act);
            end else begin
                mon_exp = sb.pop_front();
                chk("bundle", 32'(mon_act), 32'(mon_exp));
            end
        end
    end

    function automatic int sat(input int v);
        return (v >= SMAX) ? SMAX : v + 1;
    endfunction

    // One clock cycle, entered and left 1 time unit after a rising edge.
    task automatic step(input bit iv, input int op, input int s1, input int s2, input int d,
                        input bit fl, input bit ordy);
        logic [10:0] ctl;
        bit legal, use1, use2, haz, rdy;
        in_valid  = iv;
        opcode    = 6'(op);
        src1      = 5'(s1);
        src2      = 5'(s2);
        dest      = 5'(d);
        flush     = fl;
        out_ready = ordy;
        #1;
        ctl  = ref_ctl(op, legal);
        use1 = legal && op != 0 && op != 42;
        use2 = legal && op != 0 && !ctl[2];
        haz  = m_valid && m_op == 36 && m_d != 0 && ((use1 && s1 == m_d) || (use2 && s2 == m_d));
        rdy  = !fl && !haz && (!m_valid || ordy);
        chk("in_ready", 32'(in_ready), 32'(rdy));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("stall_count", 32'(stall_count), 32'(m_stall));
        chk("flush_count", 32'(flush_count), 32'(m_flush));
        if (!m_valid) chk("idle_ctl_zero", 32'(dut_ctl()), 32'd0);
`ifdef CTRL_ILLEGAL_TRAP_EN
        chk("illegal_op", 32'(illegal_op), 32'(m_illegal));
`endif
        if (fl) begin
            if (m_valid) void'(sb.pop_front());
            m_valid = 1'b0;
            m_flush = sat(m_flush);
        end else if (iv && rdy) begin
            sb.push_back({ctl, 5'(s1), 5'(s2), 5'(d)});
            m_valid = 1'b1;
            m_op    = op;
            m_d     = d;
            if (!legal) m_illegal = 1'b1;
        end else if (m_valid && ordy) begin
            m_valid = 1'b0;
            if (haz && iv) m_stall = sat(m_stall);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        opcode    = 6'd1;
        flush     = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("in_ready_in_reset", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("in_ready_in_reset", 32'(in_ready), 32'd0);
        chk("out_valid_reset", 32'(out_valid), 32'd0);
        chk("bundle_reset", 32'({dut_ctl(), out_src1, out_src2, out_dest}), 32'd0);
        chk("counters_reset", 32'({stall_count, flush_count}), 32'd0);
        rst       = 1'b0;
        in_valid  = 1'b0;
        m_valid   = 1'b0;
        m_stall   = 0;
        m_flush   = 0;
        m_illegal = 1'b0;
        sb.delete();
    endtask

    initial begin
        do_reset();
        // ADD then drain
        step(1, 1, 1, 2, 3, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        // SUB held three cycles, then released with AND accepted the same cycle
        step(1, 3, 1, 2, 3, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 5, 4, 5, 6, 0, 0);
        step(1, 5, 4, 5, 6, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        // Load-use: dest=4 stalls once, dest=0 does not
        step(1, 36, 1, 2, 4, 0, 1);
        step(1, 1, 4, 5, 6, 0, 1);
        step(1, 1, 4, 5, 6, 0, 1);
        step(1, 36, 1, 2, 0, 0, 1);
        step(1, 1, 0, 5, 6, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        // ST src2 vs BEZ src2 behind LD dest=7
        step(1, 36, 1, 2, 7, 0, 1);
        step(1, 37, 1, 7, 0, 0, 1);
        step(1, 37, 1, 7, 0, 0, 1);
        step(1, 36, 1, 2, 7, 0, 1);
        step(1, 40, 1, 7, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        // Flush over held BNE, then flush coincident with a load-use hazard
        step(1, 41, 1, 2, 3, 0, 0);
        step(1, 1, 1, 2, 3, 1, 0);
        step(1, 36, 1, 2, 3, 0, 1);
        step(1, 1, 3, 5, 6, 1, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        // Undefined opcode issues as NOP
        step(1, 2, 1, 2, 3, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        // Five stalls saturate the 2-bit counter
        for (int i = 0; i < 5; i++) begin
            step(1, 36, 1, 2, 5, 0, 1);
            step(1, 3, 5, 1, 6, 0, 1);
            step(1, 3, 5, 1, 6, 0, 1);
        end
        step(0, 0, 0, 0, 0, 0, 1);
        chk("stall_saturated", 32'(stall_count), 32'(SMAX));
        // Mid-stream reset drops the held instruction
        step(1, 36, 1, 2, 5, 0, 0);
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 499) begin
                do_reset();
            end else begin
                int op;
                op = legal_ops[$urandom_range(0, 17)];
                if ($urandom_range(0, 3) == 0) op = 36;
                if ($urandom_range(0, 7) == 0) op = int'($urandom_range(0, 63));
                step($urandom_range(0, 3) != 0, op,
                     int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                     $urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0);
            end
        end
        step(0, 0, 0, 0, 0, 0, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
